// File: rtl/xgmii_rx_fcs_check.sv
// xgmii_rx_fcs_check
//   Receive-side FCS checker for a 64-bit XGMII stream. Detects Start, runs
//   the reflected CRC32 (poly 0xEDB88320, init 0xFFFFFFFF) over every data
//   byte after the SFD up to the byte before Terminate (FCS included), and
//   validates the frame by the residue 0xDEBB20E3. One word per clock, no stall.
//
//   Optional build macro: XGMII_RX_FCS_LANE4_START_EN
//     When defined, a Start in lane 4 (rxc = 8'h10) is also accepted. In that
//     case the preamble spills into lanes 0-3 of the next word.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   xgmii_rxd      in   64-bit data, lane i = [8i+7:8i], lane 0 first on the wire
//   xgmii_rxc      in   8-bit control, bit i set = lane i is a control character
//   rx_frame_done  out  one-cycle pulse, status outputs valid in this cycle
//   rx_crc_ok      out  residue matched and no protocol error
//   rx_frame_err   out  protocol error seen in the frame
//   rx_runt        out  rx_frame_len < MIN_LEN
//   rx_oversize    out  rx_frame_len > MAX_LEN
//   rx_frame_len   out  bytes after SFD up to Terminate (FCS included), saturating
//   rx_good_cnt    out  frames with rx_crc_ok = 1 (wraps)
//   rx_bad_cnt     out  frames with rx_crc_ok = 0 (wraps)
module xgmii_rx_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      xgmii_rxd,
  input  logic [7:0]       xgmii_rxc,
  output logic             rx_frame_done,
  output logic             rx_crc_ok,
  output logic             rx_frame_err,
  output logic             rx_runt,
  output logic             rx_oversize,
  output logic [LEN_W-1:0] rx_frame_len,
  output logic [31:0]      rx_good_cnt,
  output logic [31:0]      rx_bad_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  CH_START    = 8'hFB;
  localparam logic [7:0]  CH_TERM     = 8'hFD;

  typedef enum logic {S_IDLE, S_DATA} state_e;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
`ifdef XGMII_RX_FCS_LANE4_START_EN
  // Set for the word following a lane-4 Start: it still carries preamble/SFD.
  logic             pre_q, pre_d;
  logic             start4_v, pre4_ok_v, pre_tail_ok_v;
`endif

  // Frame-end event handed to the status stage.
  logic             end_v, end_ok_v, end_err_v;
  logic [LEN_W-1:0] end_len_v;

  // Per-word scan working values.
  logic [31:0]      crc_v;
  logic [LEN_W-1:0] len_v;
  logic             err_v, term_v, start0_v, pre0_ok_v;
  int unsigned      lo_v;

  // Status registers.
  logic             done_q, ok_q, ferr_q, runt_q, over_q;
  logic [LEN_W-1:0] flen_q;
  logic [31:0]      good_q, bad_q;

  // Byte-serial reflected CRC step; equivalent to one table lookup.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] l);
    return (l == '1) ? l : l + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      crc_q   <= CRC_INIT;
      len_q   <= '0;
      err_q   <= 1'b0;
`ifdef XGMII_RX_FCS_LANE4_START_EN
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      err_q   <= err_d;
`ifdef XGMII_RX_FCS_LANE4_START_EN
      pre_q   <= pre_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    err_d     = err_q;
    end_v     = 1'b0;
    end_ok_v  = 1'b0;
    end_err_v = 1'b0;
    end_len_v = len_q;
    crc_v     = crc_q;
    len_v     = len_q;
    err_v     = err_q;
    term_v    = 1'b0;
    lo_v      = 0;
    start0_v  = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == CH_START);
    pre0_ok_v = (xgmii_rxd[63:8] == 56'hD5_5555_5555_5555);
`ifdef XGMII_RX_FCS_LANE4_START_EN
    pre_d         = 1'b0;
    start4_v      = (xgmii_rxc == 8'h10) && (xgmii_rxd[39:32] == CH_START);
    pre4_ok_v     = (xgmii_rxd[63:40] == 24'h55_5555);
    pre_tail_ok_v = (xgmii_rxc[3:0] == 4'h0) && (xgmii_rxd[31:0] == 32'hD555_5555);
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start0_v) begin
          state_d = S_DATA;
          crc_d   = CRC_INIT;
          len_d   = '0;
          err_d   = !pre0_ok_v;
        end
`ifdef XGMII_RX_FCS_LANE4_START_EN
        else if (start4_v) begin
          state_d = S_DATA;
          crc_d   = CRC_INIT;
          len_d   = '0;
          err_d   = !pre4_ok_v;
          pre_d   = 1'b1;
        end
`endif
      end

      S_DATA: begin
        if (start0_v) begin
          // Restart: report the old frame as errored and open the new one.
          end_v     = 1'b1;
          end_err_v = 1'b1;
          end_ok_v  = 1'b0;
          end_len_v = len_q;
          crc_d     = CRC_INIT;
          len_d     = '0;
          err_d     = !pre0_ok_v;
        end else begin
`ifdef XGMII_RX_FCS_LANE4_START_EN
          if (pre_q) begin
            lo_v  = 4;
            err_v = err_v | !pre_tail_ok_v;
          end
`endif
          // Lanes in wire order; everything from the first Terminate on is ignored.
          for (int unsigned i = 0; i < 8; i++) begin
            if (i >= lo_v && !term_v) begin
              if (!xgmii_rxc[i]) begin
                crc_v = crc_byte(crc_v, xgmii_rxd[8*i +: 8]);
                len_v = sat_inc(len_v);
              end else if (xgmii_rxd[8*i +: 8] == CH_TERM) begin
                term_v = 1'b1;
              end else begin
                err_v = 1'b1;
              end
            end
          end
          // An all-control word without Terminate also ends the frame (as an error).
          if (term_v || (xgmii_rxc == 8'hFF)) begin
            end_v     = 1'b1;
            end_err_v = err_v | !term_v;
            end_ok_v  = !(err_v | !term_v) && (crc_v == CRC_RESIDUE);
            end_len_v = len_v;
            state_d   = S_IDLE;
          end else begin
            crc_d = crc_v;
            len_d = len_v;
            err_d = err_v;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      ferr_q <= 1'b0;
      runt_q <= 1'b0;
      over_q <= 1'b0;
      flen_q <= '0;
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      done_q <= end_v;
      if (end_v) begin
        ok_q   <= end_ok_v;
        ferr_q <= end_err_v;
        runt_q <= 32'(end_len_v) < MIN_LEN;
        over_q <= 32'(end_len_v) > MAX_LEN;
        flen_q <= end_len_v;
        if (end_ok_v) good_q <= good_q + 32'd1;
        else          bad_q  <= bad_q + 32'd1;
      end
    end
  end

  assign rx_frame_done = done_q;
  assign rx_crc_ok     = ok_q;
  assign rx_frame_err  = ferr_q;
  assign rx_runt       = runt_q;
  assign rx_oversize   = over_q;
  assign rx_frame_len  = flen_q;
  assign rx_good_cnt   = good_q;
  assign rx_bad_cnt    = bad_q;

endmodule
